lcd_cmd_seq: RTL and testbench

Upstream command/pixel sequencer for the LCD display controller. It accepts 3-bit display commands from a host through a 4-entry FIFO, issues them to the controller one at a time on `cmd`/`cmd_valid`, and honours the controller's `busy`. For a load command (cmd 1) it fetches the 64 pixels of an 8x8 image from a 1-cycle-latency image memory and streams them on `datain` in the exact cycles the controller samples them.

---
 rtl/lcd_cmd_seq.sv | 166 ++++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_seq.sv
// Host command sequencer for the LCD controller: buffers host commands in a small FIFO,
// issues them one at a time, and streams an 8x8 image from memory for load commands.
module lcd_cmd_seq #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] host_cmd_i,
  input  logic       host_valid_i,
  output logic       host_ready_o,
  output logic       img_rd_o,
  output logic [5:0] img_addr_o,
  input  logic [7:0] img_data_i,
  output logic [2:0] cmd_o,
  output logic       cmd_valid_o,
  input  logic       busy_i,
  output logic [7:0] datain_o,
  output logic       cmd_drop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [2:0]  CMD_LOAD = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREF,
    S_ISSUE,
    S_LOAD,
    S_GUARD,
    S_WAITB
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [2:0]    cmd_q, cmd_d;
  logic [5:0]    idx_q, idx_d;
  logic          loaded_q, loaded_d;
  logic          rd_prev_q;
  logic [7:0]    datain_q;
  logic          push, pop;
  logic [2:0]    head;

  assign head         = fifo_q[rd_ptr_q];
  assign host_ready_o = (count_q != FULL_CNT);
  assign push         = host_valid_i && host_ready_o;
  assign cmd_o        = cmd_q;
  assign datain_o     = datain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= host_cmd_i;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      idx_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
    end
  end

  // Reads run two addresses ahead of the LOAD index so pixel k lands on datain in LOAD cycle k.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    loaded_d    = loaded_q;
    pop         = 1'b0;
    cmd_drop_o  = 1'b0;
    cmd_valid_o = 1'b0;
    img_rd_o    = 1'b0;
    img_addr_o  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head == CMD_LOAD) begin
            state_d = S_PREF;
          end else if (loaded_q) begin
            cmd_d   = head;
            state_d = S_ISSUE;
          end else begin
            cmd_drop_o = 1'b1;
          end
        end
      end
      S_PREF: begin
        img_rd_o   = 1'b1;
        img_addr_o = 6'd0;
        cmd_d      = CMD_LOAD;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        cmd_valid_o = 1'b1;
        idx_d       = '0;
        if (cmd_q == CMD_LOAD) begin
          img_rd_o   = 1'b1;
          img_addr_o = 6'd1;
          state_d    = S_LOAD;
        end else begin
          state_d = S_GUARD;
        end
      end
      S_LOAD: begin
        if (idx_q <= 6'd61) begin
          img_rd_o   = 1'b1;
          img_addr_o = idx_q + 6'd2;
        end
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'd63) begin
          loaded_d = 1'b1;
          state_d  = S_GUARD;
        end
      end
      // busy may rise a cycle after the strobe, so it is not trusted here.
      S_GUARD: state_d = S_WAITB;
      S_WAITB: begin
        if (!busy_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_prev_q <= 1'b0;
      datain_q  <= '0;
    end else begin
      rd_prev_q <= img_rd_o;
      if (rd_prev_q) begin
        datain_q <= img_data_i;
      end
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq: scoreboard of expected commands/pixels plus a
// table of command/busy patterns with their expected issue-to-issue spacing.
module tb_lcd_cmd_seq;

  typedef struct packed {
    logic [2:0] cmd;
    logic       drop;
  } exp_t;

  typedef struct {
    logic [2:0] cmd;
    int         busyLen;
    int         expGap;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic [2:0] hostCmd = '0;
  logic       hostValid = 1'b0;
  logic       hostReady;
  logic       imgRd;
  logic [5:0] imgAddr;
  logic [7:0] imgData = '0;
  logic [2:0] cmd;
  logic       cmdValid;
  logic       busy = 1'b0;
  logic [7:0] datain;
  logic       cmdDrop;

  logic [7:0] mem [64];
  exp_t       cmdQ [$];
  logic [7:0] pixQ [$];
  vec_t       vecs [8];

  int testsRun = 0;
  int failCount = 0;
  int loadK = -1;
  int rdRun = 0;
  int dropSeen = 0;

  lcd_cmd_seq #(.FIFO_DEPTH(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .host_cmd_i  (hostCmd),
    .host_valid_i(hostValid),
    .host_ready_o(hostReady),
    .img_rd_o    (imgRd),
    .img_addr_o  (imgAddr),
    .img_data_i  (imgData),
    .cmd_o       (cmd),
    .cmd_valid_o (cmdValid),
    .busy_i      (busy),
    .datain_o    (datain),
    .cmd_drop_o  (cmdDrop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imgRd) imgData <= mem[imgAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] c, input bit expAccept, input bit expDrop);
    exp_t e;
    checkOutput("host_ready", hostReady, expAccept);
    hostCmd   = c;
    hostValid = 1'b1;
    if (expAccept) begin
      e.cmd  = c;
      e.drop = expDrop;
      cmdQ.push_back(e);
      if (c == 3'd1 && !expDrop) begin
        for (int k = 0; k < 64; k++) pixQ.push_back(mem[k]);
      end
    end
    @(negedge clk);
    hostValid = 1'b0;
  endtask

  task automatic waitIssue(input int maxCyc, output int n);
    n = 0;
    while (!cmdValid && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput("issue_seen", cmdValid, 1);
  endtask

  task automatic waitDrain(input int maxCyc);
    int n = 0;
    while ((cmdQ.size() != 0 || loadK >= 0) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue", cmdQ.size(), 0);
  endtask

  // Scoreboard monitor: pixels, read bursts, issued and dropped commands.
  always @(negedge clk) begin
    exp_t e;
    if (!rstN) begin
      loadK = -1;
      rdRun = 0;
    end else begin
      if (loadK >= 0) begin
        checkOutput("datain", datain, pixQ.pop_front());
        loadK++;
        if (loadK == 64) loadK = -1;
      end
      if (imgRd) begin
        checkOutput("img_addr", imgAddr, rdRun);
        rdRun++;
      end else if (rdRun != 0) begin
        checkOutput("img_rd_burst_len", rdRun, 64);
        rdRun = 0;
      end
      if (cmdValid) begin
        if (cmdQ.size() == 0) begin
          checkOutput("cmd_valid_unexpected", cmdValid, 0);
        end else begin
          e = cmdQ.pop_front();
          if (e.drop) begin
            checkOutput("issued_instead_of_drop", cmdValid, 0);
          end else begin
            checkOutput("cmd", cmd, e.cmd);
            if (e.cmd == 3'd1 && cmd == 3'd1) loadK = 0;
          end
        end
      end
      if (cmdDrop) begin
        dropSeen++;
        if (cmdQ.size() == 0) begin
          checkOutput("cmd_drop_unexpected", cmdDrop, 0);
        end else begin
          e = cmdQ.pop_front();
          checkOutput("drop_vs_issue", cmdDrop, e.drop);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int dropsBefore;

    vecs[0] = '{3'd0, 0, 4};
    vecs[1] = '{3'd2, 1, 5};
    vecs[2] = '{3'd3, 3, 7};
    vecs[3] = '{3'd4, 0, 5};
    vecs[4] = '{3'd1, 70, 74};
    vecs[5] = '{3'd5, 6, 10};
    vecs[6] = '{3'd6, 20, 24};
    vecs[7] = '{3'd7, 0, 0};
    for (int k = 0; k < 64; k++) mem[k] = 8'(k);

    #1 rstN = 1'b0;
    #1;
    checkOutput("rst_cmd", cmd, 0);
    checkOutput("rst_cmd_valid", cmdValid, 0);
    checkOutput("rst_datain", datain, 0);
    checkOutput("rst_img_rd", imgRd, 0);
    checkOutput("rst_img_addr", imgAddr, 0);
    checkOutput("rst_cmd_drop", cmdDrop, 0);
    checkOutput("rst_host_ready", hostReady, 1);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Commands before any load are discarded.
    dropsBefore = dropSeen;
    applyStimulus(3'd2, 1, 1);
    applyStimulus(3'd4, 1, 1);
    waitDrain(20);
    repeat (2) @(negedge clk);
    checkOutput("drop_count", dropSeen - dropsBefore, 2);
    checkOutput("drop_fifo_empty", hostReady, 1);
    checkOutput("drop_cmd_unchanged", cmd, 0);

    // Load then refresh, refresh held off by busy after the load.
    applyStimulus(3'd1, 1, 0);
    applyStimulus(3'd0, 1, 0);
    waitIssue(10, n);
    repeat (65) @(negedge clk);
    busy = 1'b1;
    repeat (20) @(negedge clk);
    busy = 1'b0;
    waitIssue(20, n);
    checkOutput("load_to_refresh_gap", 85 + n, 87);
    checkOutput("datain_hold", datain, 63);
    waitDrain(20);
    repeat (4) @(negedge clk);

    // FIFO fills behind a load; full push refused, then push refused during a pop at full.
    for (int k = 0; k < 64; k++) mem[k] = 8'($urandom_range(0, 255));
    busy = 1'b1;
    applyStimulus(3'd1, 1, 0);
    applyStimulus(3'd2, 1, 0);
    applyStimulus(3'd3, 1, 0);
    applyStimulus(3'd4, 1, 0);
    applyStimulus(3'd5, 1, 0);
    applyStimulus(3'd6, 0, 0);
    repeat (70) @(negedge clk);
    checkOutput("ready_while_waitb", hostReady, 0);
    hostCmd   = 3'd7;
    hostValid = 1'b1;
    busy      = 1'b0;
    @(negedge clk);
    checkOutput("ready_at_pop", hostReady, 0);
    @(posedge clk);
    #1;
    hostValid = 1'b0;
    checkOutput("ready_after_pop", hostReady, 1);
    waitDrain(100);
    repeat (4) @(negedge clk);
    checkOutput("last_cmd_hold", cmd, 5);

    // Issue spacing under assorted late/long busy patterns.
    for (int k = 0; k < 64; k++) mem[k] = 8'(k * 7 + 3);
    applyStimulus(vecs[0].cmd, 1, 0);
    waitIssue(10, n);
    checkOutput("push_to_issue", 1 + n, 2);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i + 1].cmd, 1, 0);
      @(negedge clk);
      if (vecs[i].busyLen > 0) busy = 1'b1;
      repeat (vecs[i].busyLen) @(negedge clk);
      busy = 1'b0;
      waitIssue(300, n);
      checkOutput($sformatf("gap_vec%0d", i), 2 + vecs[i].busyLen + n, vecs[i].expGap);
    end
    waitDrain(20);
    repeat (4) @(negedge clk);

    // Reset in LOAD cycle 30 aborts everything and forgets the image.
    applyStimulus(3'd1, 1, 0);
    applyStimulus(3'd2, 1, 0);
    waitIssue(10, n);
    repeat (31) @(negedge clk);
    #1 rstN = 1'b0;
    cmdQ.delete();
    pixQ.delete();
    #1;
    checkOutput("abort_cmd", cmd, 0);
    checkOutput("abort_cmd_valid", cmdValid, 0);
    checkOutput("abort_datain", datain, 0);
    checkOutput("abort_img_rd", imgRd, 0);
    checkOutput("abort_img_addr", imgAddr, 0);
    checkOutput("abort_cmd_drop", cmdDrop, 0);
    checkOutput("abort_host_ready", hostReady, 1);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    dropsBefore = dropSeen;
    applyStimulus(3'd3, 1, 1);
    waitDrain(20);
    repeat (3) @(negedge clk);
    checkOutput("post_reset_drop_count", dropSeen - dropsBefore, 1);
    checkOutput("post_reset_cmd", cmd, 0);
    checkOutput("post_reset_ready", hostReady, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
